// File: rtl/modulo_is_zero_pkg.sv
// Shared types and constants for the modulo_is_zero divisor-test engine.
package modulo_is_zero_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/modulo_is_zero_div_step.sv
// One combinational restoring-division step: shift in a dividend bit and
// subtract the divisor when the shifted remainder reaches it.
module modulo_is_zero_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   rem_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           ge;

  // A set top bit means the true shifted value is at least 2^(WIDTH+1),
  // which already exceeds any divisor.
  assign shifted = {rem_i[WIDTH-1:0], bit_i};
  assign ge      = rem_i[WIDTH] | (shifted >= {1'b0, b_i});
  assign diff    = shifted - {1'b0, b_i};
  assign rem_o   = ge ? diff : shifted;

endmodule

// File: rtl/modulo_is_zero.sv
// Multi-cycle test of (a mod b) == 0 using bit-serial restoring division,
// with valid/ready channels for operands and verdict.
module modulo_is_zero
  import modulo_is_zero_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_i,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             y,
  output logic             valid_o,
  input  logic             ready_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready_i and valid_o depend only on the registered state.
  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH:0]   rem_step;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             y_q, y_d;

  modulo_is_zero_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (a_q[WIDTH-1]),
    .b_i   (b_q),
    .rem_o (rem_step)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          a_d     = a;
          b_d     = b;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH);
          y_d     = 1'b0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        // Dividend is consumed MSB first from the top of a shift register.
        if (cnt_q != '0) begin
          rem_d = rem_step;
          a_d   = {a_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q - CW'(1);
        end else begin
          y_d     = (rem_q == '0) && (b_q != '0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ready_o) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign ready_i = (state_q == ST_IDLE);
  assign valid_o = (state_q == ST_DONE);
  assign y       = y_q;

endmodule

// File: tb/tb_modulo_is_zero.sv
// Randomized and directed bench for modulo_is_zero against an a%b model.
module tb_modulo_is_zero;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid_i = 1'b0;
  logic             ready_o = 1'b1;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             ready_i;
  logic             valid_o;
  logic             y;

  modulo_is_zero #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (valid_i),
    .ready_i (ready_i),
    .a       (a),
    .b       (b),
    .y       (y),
    .valid_o (valid_o),
    .ready_o (ready_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [0:0]  exp_q[$];
  int unsigned acc_cyc  = 0;
  int unsigned done_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [0:0] model(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb);
    if (bb == '0) return 1'b0;
    return ((aa % bb) == '0) ? 1'b1 : 1'b0;
  endfunction

  // driver tasks (all called at #1 after a rising edge)
  task automatic present(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb);
    a       = aa;
    b       = bb;
    valid_i = 1'b1;
  endtask

  task automatic wait_accept();
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ready_i === 1'b1) begin
        @(posedge clk); #1;
        acc_cyc = cyc;
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("accept_timeout", 64'(got), 64'd1);
    if (got) exp_q.push_back(model(a, b));
    valid_i = 1'b0;
  endtask

  task automatic accept_op(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb);
    present(aa, bb);
    wait_accept();
  endtask

  task automatic collect(input int hold, input string tag);
    bit         seen   = 1'b0;
    bit         stable = 1'b1;
    logic [0:0] exp_y;
    ready_o = (hold > 0) ? 1'b0 : 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (valid_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_valid_timeout"}, 64'(seen), 64'd1);
    if (!seen) begin
      ready_o = 1'b1;
      return;
    end
    done_cyc = cyc;
    chk({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(WIDTH + 1));
    chk({tag, "_ready_i_busy"}, 64'(ready_i), 64'd0);
    exp_y = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
    chk({tag, "_y"}, 64'(y), 64'(exp_y));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (valid_o !== 1'b1 || y !== exp_y || ready_i !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) chk({tag, "_hold_stable"}, 64'(stable), 64'd1);
    ready_o = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, 64'(valid_o), 64'd0);
    chk({tag, "_ready_back"}, 64'(ready_i), 64'd1);
  endtask

  logic [WIDTH-1:0] dir_a[8];
  logic [WIDTH-1:0] dir_b[8];

  initial begin
    logic [WIDTH-1:0] ra, rb;
    bit quiet;
    dir_a = '{32'd91, 32'd97, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd12, 32'd3, 32'd17};
    dir_b = '{32'd7,  32'd7,  32'hFFFF_FFFF, 32'd2,         32'd5, 32'd0,  32'd5, 32'd1};

    // reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_i", 64'(ready_i), 64'd1);
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ready_i", 64'(ready_i), 64'd1);
    chk("idle_valid_o", 64'(valid_o), 64'd0);

    // directed operands and boundary cases
    for (int i = 0; i < 8; i++) begin
      accept_op(dir_a[i], dir_b[i]);
      collect(0, "dir");
    end

    // back-pressure
    accept_op(32'd100, 32'd10);
    collect(20, "bp");

    // valid_i held while busy: accepted on first IDLE cycle
    accept_op(32'd1000, 32'd8);
    present(32'd1001, 32'd8);
    collect(0, "b2b0");
    wait_accept();
    chk("b2b_gap", 64'(acc_cyc - done_cyc), 64'd2);
    collect(0, "b2b1");

    // abort mid-computation
    accept_op(32'd1234, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid_o", 64'(valid_o), 64'd0);
    chk("abort_ready_i", 64'(ready_i), 64'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(posedge clk); #1;
      if (valid_o !== 1'b0) quiet = 1'b0;
    end
    chk("abort_no_stale", 64'(quiet), 64'd1);
    accept_op(32'd49, 32'd7);
    collect(0, "post_abort");

    // randomized pairs
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: begin ra = $urandom(); rb = $urandom(); end
        1: begin rb = WIDTH'($urandom_range(0, 16)); ra = rb * WIDTH'($urandom_range(0, 100000)); end
        2: begin ra = $urandom(); rb = WIDTH'($urandom_range(1, 12)); end
        default: begin
          ra = $urandom();
          case ($urandom_range(0, 2))
            0: rb = ra;
            1: rb = '1;
            default: rb = WIDTH'(1);
          endcase
        end
      endcase
      accept_op(ra, rb);
      collect($urandom_range(0, 3), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
